// File: rtl/line_doubler_pkg.sv
// Shared constants, FSM state and line-buffer ring types for the vertical 2x line doubler.
package line_doubler_pkg;
   localparam int PIX_W    = 8;
   localparam int LINE_PIX = 640;
   localparam int LINES    = 480;
   localparam int X_W      = $clog2(LINE_PIX);
   localparam int Y_W      = $clog2(2*LINES);

   typedef enum logic [1:0] {IDLE, ORIG, INTERP, DUP} state_t;
   typedef logic [1:0] slot_t;

   function automatic slot_t next_slot(input slot_t s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   function automatic slot_t prev_slot(input slot_t s);
      return (s == 2'd0) ? 2'd2 : s - 2'd1;
   endfunction
endpackage

// File: rtl/line_doubler_vinterp_ram.sv
// One line buffer: single write port, single registered read port.
module line_ram
   import line_doubler_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/line_doubler_vinterp.sv
// Vertical 2x upscaler: each input line is followed by a line averaged with the next one;
// the last line of a frame is duplicated. Three line buffers form a write/read ring.
module line_doubler_vinterp
   import line_doubler_pkg::*;
#(
   parameter int PIX_W    = line_doubler_pkg::PIX_W,
   parameter int LINE_PIX = line_doubler_pkg::LINE_PIX,
   parameter int LINES    = line_doubler_pkg::LINES,
   parameter int X_W      = $clog2(LINE_PIX),
   parameter int Y_W      = $clog2(2*LINES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             newline,
   input  logic             newframe,
   input  logic [PIX_W-1:0] data_in_pix,
   output logic [PIX_W-1:0] data_out,
   output logic             valid_out,
   output logic             line_start_out,
   output logic             frame_start_out,
   output logic [X_W-1:0]   out_x,
   output logic [Y_W-1:0]   out_y,
   output logic             line_err,
   output logic             frame_err
);
   localparam logic [X_W:0]   LP     = (X_W+1)'(LINE_PIX);
   localparam logic [X_W-1:0] LAST_X = X_W'(LINE_PIX-1);
   localparam logic [Y_W-1:0] NLINES = Y_W'(LINES);
   localparam logic [Y_W-1:0] LAST_Y = Y_W'(LINES-1);

   function automatic logic [PIX_W-1:0] avg_trunc(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
      logic [PIX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[PIX_W:1];
   endfunction

   logic [X_W:0]     wx;
   slot_t            ws, sel_a, sel_b, last_slot, sel_a_p1, sel_b_p1;
   logic [Y_W-1:0]   in_y, pair_y, y_p0, y_p1;
   logic [X_W-1:0]   rx, x_p1;
   state_t           state;
   logic             wr_ok, line_done, trig, flush_set, short_line, busy_err;
   logic             dup_mode, flush_pend;
   logic             vld_p1, interp_p1, first_p1;
   logic [PIX_W-1:0] q [3];
   logic [PIX_W-1:0] a_p1, b_p1, pix_p1;

   assign wr_ok      = enable && !newline && (wx < LP) && (in_y < NLINES);
   assign line_done  = wr_ok && (wx == LP - (X_W+1)'(1));
   assign trig       = line_done && (in_y != '0);
   assign flush_set  = line_done && (in_y == LAST_Y);
   assign short_line = newline && (wx != '0) && (wx < LP);
   assign busy_err   = trig && (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wx        <= '0;
         ws        <= '0;
         in_y      <= '0;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (newline)    wx <= '0;
         else if (wr_ok) wx <= wx + (X_W+1)'(1);
         if (line_done) ws <= next_slot(ws);
         if (newframe)       in_y <= '0;
         else if (line_done) in_y <= in_y + Y_W'(1);
         if (newframe && (in_y != '0) && (in_y < NLINES)) frame_err <= 1'b1;
         if (short_line || busy_err) line_err <= 1'b0 | 1'b1;
         else if (newframe)          line_err <= 1'b0;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_ram
      line_ram #(.DEPTH(LINE_PIX), .WIDTH(PIX_W), .AW(X_W)) u_ram (
         .clk  (clk),
         .we   (wr_ok && (ws == slot_t'(i))),
         .waddr(wx[X_W-1:0]),
         .wdata(data_in_pix),
         .raddr(rx),
         .rdata(q[i])
      );
   end

   // p0: FSM walks rx over the selected slots; the flush pair reuses the last line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rx         <= '0;
         sel_a      <= '0;
         sel_b      <= '0;
         pair_y     <= '0;
         dup_mode   <= 1'b0;
         flush_pend <= 1'b0;
         last_slot  <= '0;
      end else begin
         if (flush_set) begin
            flush_pend <= 1'b1;
            last_slot  <= ws;
         end
         case (state)
            IDLE: begin
               rx <= '0;
               if (trig) begin
                  state    <= ORIG;
                  sel_a    <= prev_slot(ws);
                  sel_b    <= ws;
                  pair_y   <= in_y - Y_W'(1);
                  dup_mode <= 1'b0;
               end else if (flush_pend) begin
                  state      <= ORIG;
                  sel_a      <= last_slot;
                  sel_b      <= last_slot;
                  pair_y     <= LAST_Y;
                  dup_mode   <= 1'b1;
                  flush_pend <= 1'b0;
               end
            end
            ORIG: begin
               rx <= rx + X_W'(1);
               if (rx == LAST_X) begin
                  rx    <= '0;
                  state <= dup_mode ? DUP : INTERP;
               end
            end
            default: begin
               rx <= rx + X_W'(1);
               if (rx == LAST_X) begin
                  rx    <= '0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign y_p0 = (state == ORIG) ? (pair_y << 1) : ((pair_y << 1) | Y_W'(1));

   // p1: RAM data arrives; pick slots and average
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_p1 <= 1'b0;
      else          vld_p1 <= (state != IDLE);
   end

   always_ff @(posedge clk) begin
      interp_p1 <= (state == INTERP);
      first_p1  <= (rx == '0);
      x_p1      <= rx;
      y_p1      <= y_p0;
      sel_a_p1  <= sel_a;
      sel_b_p1  <= sel_b;
   end

   always_comb begin
      a_p1 = q[0];
      b_p1 = q[0];
      case (sel_a_p1)
         2'd1:    a_p1 = q[1];
         2'd2:    a_p1 = q[2];
         default: a_p1 = q[0];
      endcase
      case (sel_b_p1)
         2'd1:    b_p1 = q[1];
         2'd2:    b_p1 = q[2];
         default: b_p1 = q[0];
      endcase
      pix_p1 = interp_p1 ? avg_trunc(a_p1, b_p1) : a_p1;
   end

   // p2: output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out        <= '0;
         valid_out       <= 1'b0;
         line_start_out  <= 1'b0;
         frame_start_out <= 1'b0;
         out_x           <= '0;
         out_y           <= '0;
      end else begin
         data_out        <= pix_p1;
         valid_out       <= vld_p1;
         line_start_out  <= vld_p1 && first_p1;
         frame_start_out <= vld_p1 && first_p1 && (y_p1 == '0);
         out_x           <= x_p1;
         out_y           <= y_p1;
      end
   end
endmodule

// File: tb/tb_line_doubler_vinterp.sv
// Directed bench for line_doubler_vinterp with 4-pixel lines and 3-line frames.
`timescale 1ns/1ps
module tb_line_doubler_vinterp;
   localparam int PIX_W = 8, LINE_PIX = 4, LINES = 3, X_W = 2, Y_W = 3;

   logic             clk = 1'b0, reset_n = 1'b0;
   logic             enable = 1'b0, newline = 1'b0, newframe = 1'b0;
   logic [PIX_W-1:0] data_in_pix = '0;
   logic [PIX_W-1:0] data_out;
   logic             valid_out, line_start_out, frame_start_out, line_err, frame_err;
   logic [X_W-1:0]   out_x;
   logic [Y_W-1:0]   out_y;

   typedef struct {int d; int x; int y; int ls; int fs; int c;} rec_t;
   rec_t q[$];
   int   cyc = 0, fs_count = 0;
   int   total = 0, bad = 0;
   int   last_px_cyc = 0, trig_c = 0, qb = 0, fb = 0, found = 0;

   line_doubler_vinterp #(.PIX_W(PIX_W), .LINE_PIX(LINE_PIX), .LINES(LINES),
                          .X_W(X_W), .Y_W(Y_W)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .newline(newline),
      .newframe(newframe), .data_in_pix(data_in_pix), .data_out(data_out),
      .valid_out(valid_out), .line_start_out(line_start_out),
      .frame_start_out(frame_start_out), .out_x(out_x), .out_y(out_y),
      .line_err(line_err), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         q.push_back('{int'(data_out), int'(out_x), int'(out_y),
                       int'(line_start_out), int'(frame_start_out), cyc});
         if (frame_start_out === 1'b1) fs_count++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hand-derived: even rows are line y/2, odd rows average to 10j+5+x, row 5 repeats line 2.
   function automatic int exp_pix(input int y, input int x);
      int j;
      j = y / 2;
      if ((y % 2) == 0 || j == LINES - 1) return 10*j + x;
      return 10*j + 5 + x;
   endfunction

   task automatic check_frame(input int base, input int n, input string tag);
      for (int i = 0; i < n && base + i < q.size(); i++) begin
         int y, x;
         y = i / LINE_PIX;
         x = i % LINE_PIX;
         check($sformatf("%s_d%0d", tag, i), q[base+i].d, exp_pix(y, x));
         check($sformatf("%s_x%0d", tag, i), q[base+i].x, x);
         check($sformatf("%s_y%0d", tag, i), q[base+i].y, y);
         check($sformatf("%s_ls%0d", tag, i), q[base+i].ls, (x == 0) ? 1 : 0);
         check($sformatf("%s_fs%0d", tag, i), q[base+i].fs, (x == 0 && y == 0) ? 1 : 0);
         if ((i % (2*LINE_PIX)) != 0)
            check($sformatf("%s_c%0d", tag, i), q[base+i].c, q[base+i-1].c + 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_pix(input int v);
      enable      = 1'b1;
      data_in_pix = PIX_W'(v);
      last_px_cyc = cyc + 1;
      tick();
      enable = 1'b0;
      tick();
   endtask

   task automatic start_line();
      newline = 1'b1;
      tick();
      newline = 1'b0;
   endtask

   task automatic start_frame();
      newframe = 1'b1;
      tick();
      newframe = 1'b0;
   endtask

   task automatic send_line(input int l);
      start_line();
      for (int x = 0; x < LINE_PIX; x++) send_pix(10*l + x);
   endtask

   initial begin
      idle(2);
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 0);
      check("rst_ls", line_start_out, 0);
      check("rst_fs", frame_start_out, 0);
      check("rst_x", out_x, 0);
      check("rst_y", out_y, 0);
      check("rst_line_err", line_err, 0);
      check("rst_frame_err", frame_err, 0);
      reset_n = 1'b1;
      idle(2);

      // nominal frame followed back-to-back by a second one
      qb = q.size(); fb = fs_count;
      start_frame(); send_line(0); send_line(1); trig_c = last_px_cyc; send_line(2);
      start_frame(); send_line(0); send_line(1); send_line(2);
      idle(40);
      check("b2b_count", q.size() - qb, 48);
      check_frame(qb, 24, "nom");
      check_frame(qb + 24, 24, "b2b");
      if (q.size() > qb) check("nom_latency", q[qb].c - trig_c, 2);
      check("b2b_fs", fs_count - fb, 2);
      check("nom_line_err", line_err, 0);
      check("nom_frame_err", frame_err, 0);

      // averaging truncation and no overflow
      qb = q.size();
      start_frame();
      start_line(); send_pix(255); send_pix(255); send_pix(0); send_pix(7);
      start_line(); send_pix(0); send_pix(255); send_pix(1); send_pix(2);
      send_line(2);
      idle(40);
      check("trn_count", q.size() - qb, 24);
      if (q.size() >= qb + 8) begin
         check("trn_orig0", q[qb].d, 255);
         check("trn_i0", q[qb+4].d, 127);
         check("trn_i1", q[qb+5].d, 255);
         check("trn_i2", q[qb+6].d, 0);
         check("trn_i3", q[qb+7].d, 4);
      end

      // short line: discarded, flagged, next full line takes its place
      qb = q.size();
      start_frame(); send_line(0);
      start_line(); send_pix(10); send_pix(11);
      start_line();
      check("short_line_err", line_err, 1);
      idle(12);
      check("short_nopair", q.size() - qb, 0);
      for (int x = 0; x < LINE_PIX; x++) send_pix(10 + x);
      send_line(2);
      idle(40);
      check("short_count", q.size() - qb, 24);
      check_frame(qb, 24, "short");
      check("short_sticky", line_err, 1);
      start_frame();
      check("short_cleared", line_err, 0);

      // truncated frame: pair 0 only, no flush, next frame restarts at row 0
      qb = q.size(); fb = fs_count;
      send_line(0); send_line(1);
      idle(30);
      start_frame();
      check("tf_frame_err", frame_err, 1);
      check("tf_count", q.size() - qb, 8);
      idle(30);
      check("tf_noflush", q.size() - qb, 8);
      check_frame(qb, 8, "tf");
      send_line(0); send_line(1); send_line(2);
      idle(40);
      check("tf_next_count", q.size() - qb, 32);
      check_frame(qb + 8, 24, "tf_next");
      check("tf_fs", fs_count - fb, 2);

      // asynchronous reset in the middle of an interpolated line
      start_frame(); send_line(0); send_line(1);
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         @(negedge clk);
         if (valid_out === 1'b1 && out_y == 3'd1) found = 1;
      end
      check("arst_interp_seen", found, 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", valid_out, 0);
      check("arst_data", data_out, 0);
      check("arst_y", out_y, 0);
      idle(3);
      reset_n = 1'b1;
      check("arst_frame_err", frame_err, 0);
      qb = q.size(); fb = fs_count;
      idle(20);
      check("arst_no_resume", q.size() - qb, 0);
      start_frame(); send_line(0); send_line(1); send_line(2);
      idle(40);
      check("arst_count", q.size() - qb, 24);
      check_frame(qb, 24, "arst");
      check("arst_fs", fs_count - fb, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
